dac_segment_encoder: RTL and testbench

- Data-side counterpart of the clock distribution tree.
- Converts an unsigned DAC code into the segmented drive pattern: 17 thermometer units, 6 binary cells and one redundant LSB cell. These are the same segments the distribution tree clocks through its clkout_therm_*/clkout_binary_* outputs.
- Pipelined, with data-weighted-averaging (DWA) rotation of the thermometer units, saturation detection and pdb-driven flush.
- Sits directly ahead of the segment retiming latches.

---
 rtl/dac_segment_encoder.sv | 164 ++++++++++++++++
 tb/tb_dac_segment_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_segment_encoder.sv
// dac_segment_encoder: converts an unsigned DAC code into the segmented drive
// pattern (thermometer units, binary cells, redundant LSB cell). The block is a
// three-stage pipeline with DWA rotation of the thermometer units, saturation
// detection with a sticky flag, and a pdb-driven flush.
module dac_segment_encoder #(
    parameter int N_THERM = 17,
    parameter int N_BIN   = 6,
    parameter int CODE_W  = 11,
    parameter int PTR_W   = 5
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               pdb,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               code_valid,
    input  logic               dem_en,
    input  logic               cal_lsb_sel,
    input  logic               sat_clr,
    output logic [N_THERM-1:0] therm_out,
    output logic [N_BIN-1:0]   bin_out,
    output logic               bin0_red_out,
    output logic               out_valid,
    output logic               sat_flag,
    output logic [PTR_W-1:0]   ptr_out
);

    localparam int CODE_MAX = N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1;
    localparam int N_W      = CODE_W - N_BIN;
    localparam int SUM_W    = PTR_W + 1;

    localparam logic [CODE_W-1:0] CODE_MAX_V = CODE_W'(CODE_MAX);

    // Stage 1 registers
    logic              r_s1_valid;
    logic [CODE_W-1:0] r_s1_code;
    logic              r_sat;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [N_THERM-1:0] r_s2_therm;
    logic [N_BIN-1:0]   r_s2_bin;
    logic               r_s2_red;
    logic [PTR_W-1:0]   r_ptr;

    // Stage 3 (output) registers
    logic               r_out_valid;
    logic [N_THERM-1:0] r_therm;
    logic [N_BIN-1:0]   r_bin;
    logic               r_red;

    // Combinational helpers
    logic                 w_sat;
    logic [N_W-1:0]       w_n;
    logic [N_BIN-1:0]     w_b;
    logic [N_THERM-1:0]   w_fill;
    logic [2*N_THERM-1:0] w_dbl;
    logic [N_THERM-1:0]   w_rot;
    logic [SUM_W-1:0]     w_sum;
    logic [PTR_W-1:0]     w_ptr_next;

    assign w_sat = code_in > CODE_MAX_V;

    // Split the stage-1 code into the unit count and the binary remainder.
    assign w_n = r_s1_code[CODE_W-1:N_BIN];
    assign w_b = r_s1_code[N_BIN-1:0];

    // n lowest units set; n = N_THERM shifts every one out, giving all ones.
    assign w_fill = ~({N_THERM{1'b1}} << w_n);

    // Rotate the fill left by ptr modulo N_THERM: the upper half of the shifted
    // doubled word wraps the high units back into the low indices.
    assign w_dbl = {w_fill, w_fill} << r_ptr;
    assign w_rot = w_dbl[2*N_THERM-1:N_THERM];

    // ptr < N_THERM and n <= N_THERM, so a single subtraction is a full modulo.
    assign w_sum      = SUM_W'(r_ptr) + SUM_W'(w_n);
    assign w_ptr_next = (w_sum >= SUM_W'(N_THERM)) ? PTR_W'(w_sum - SUM_W'(N_THERM))
                                                   : PTR_W'(w_sum);

    // Stage 1: capture the code, clamping anything above CODE_MAX.
    always_ff @(posedge clkin or negedge rstb) begin
        // NOTE: clocked state uses <= so every stage samples the pre-edge value of its predecessor.
        if (!rstb) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (!pdb) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else begin
            r_s1_valid <= code_valid;
            if (code_valid) begin
                r_s1_code <= w_sat ? CODE_MAX_V : code_in;
            end
        end
    end

    // Sticky saturation flag: set beats clear, power-down clears.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            r_sat <= 1'b0;
        end else if (!pdb) begin
            r_sat <= 1'b0;
        end else if (code_valid && w_sat) begin
            r_sat <= 1'b1;
        end else if (sat_clr) begin
            r_sat <= 1'b0;
        end
    end

    // Stage 2: thermometer mask, pointer update and binary routing; bubbles hold everything.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            r_s2_valid <= 1'b0;
            r_s2_therm <= '0;
            r_s2_bin   <= '0;
            r_s2_red   <= 1'b0;
            r_ptr      <= '0;
        end else if (!pdb) begin
            r_s2_valid <= 1'b0;
            r_s2_therm <= '0;
            r_s2_bin   <= '0;
            r_s2_red   <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_therm <= dem_en ? w_rot : w_fill;
                r_ptr      <= dem_en ? w_ptr_next : '0;
                r_s2_bin   <= cal_lsb_sel ? {w_b[N_BIN-1:1], 1'b0} : w_b;
                r_s2_red   <= cal_lsb_sel & w_b[0];
            end
        end
    end

    // Stage 3: output registers, updated only by valid slots.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            r_out_valid <= 1'b0;
            r_therm     <= '0;
            r_bin       <= '0;
            r_red       <= 1'b0;
        end else if (!pdb) begin
            r_out_valid <= 1'b0;
            r_therm     <= '0;
            r_bin       <= '0;
            r_red       <= 1'b0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_therm <= r_s2_therm;
                r_bin   <= r_s2_bin;
                r_red   <= r_s2_red;
            end
        end
    end

    assign therm_out    = r_therm;
    assign bin_out      = r_bin;
    assign bin0_red_out = r_red;
    assign out_valid    = r_out_valid;
    assign sat_flag     = r_sat;
    assign ptr_out      = r_ptr;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Directed testbench for dac_segment_encoder. A code driven just after edge k
// is expected on the outputs just after edge k+3.
module tb_dac_segment_encoder;

    logic        clkin;
    logic        rstb;
    logic        pdb;
    logic [10:0] code_in;
    logic        code_valid;
    logic        dem_en;
    logic        cal_lsb_sel;
    logic        sat_clr;
    logic [16:0] therm_out;
    logic [5:0]  bin_out;
    logic        bin0_red_out;
    logic        out_valid;
    logic        sat_flag;
    logic [4:0]  ptr_out;

    int total = 0;
    int bad   = 0;

    dac_segment_encoder dut (
        .clkin        (clkin),
        .rstb         (rstb),
        .pdb          (pdb),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .dem_en       (dem_en),
        .cal_lsb_sel  (cal_lsb_sel),
        .sat_clr      (sat_clr),
        .therm_out    (therm_out),
        .bin_out      (bin_out),
        .bin0_red_out (bin0_red_out),
        .out_valid    (out_valid),
        .sat_flag     (sat_flag),
        .ptr_out      (ptr_out)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        sat_clr    = 1'b0;
        rstb       = 1'b0;
        tick();
        rstb       = 1'b1;
    endtask

    // Drive one valid code for a single edge.
    task automatic send(input logic [10:0] code);
        code_in    = code;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; pdb = 1'b1; code_in = '0; code_valid = 1'b0;
        dem_en = 1'b0; cal_lsb_sel = 1'b0; sat_clr = 1'b0;
        ticks(2);
        total++;
        if ({therm_out, bin_out, bin0_red_out, out_valid, sat_flag, ptr_out} !== 31'd0) begin
            bad++;
            $display("FAIL reset_state: got therm=%h bin=%h red=%b v=%b sat=%b ptr=%0d want all 0",
                     therm_out, bin_out, bin0_red_out, out_valid, sat_flag, ptr_out);
        end
        rstb = 1'b1;
    endtask

    task automatic test_fixed_fill();
        dem_en = 1'b0; cal_lsb_sel = 1'b0;
        send(11'd200);
        ticks(1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL fixed_early_valid: got %b want 0", out_valid);
        end
        tick();
        total++;
        if (therm_out !== 17'h00007) begin
            bad++; $display("FAIL fixed_therm: got %h want 00007", therm_out);
        end
        total++;
        if ({bin_out, bin0_red_out, out_valid, ptr_out} !== {6'b001000, 1'b0, 1'b1, 5'd0}) begin
            bad++; $display("FAIL fixed_bin: got bin=%b red=%b v=%b ptr=%0d want 001000 0 1 0",
                            bin_out, bin0_red_out, out_valid, ptr_out);
        end
        tick();
        total++;
        if ({therm_out, out_valid} !== {17'h00007, 1'b0}) begin
            bad++; $display("FAIL fixed_hold: got therm=%h v=%b want 00007 0", therm_out, out_valid);
        end
    endtask

    task automatic test_dwa_wrap();
        do_reset();
        dem_en = 1'b1; cal_lsb_sel = 1'b0;
        send(11'd640);
        tick();                 // bubble
        send(11'd640);
        total++;
        if ({therm_out, out_valid, ptr_out} !== {17'h003FF, 1'b1, 5'd10}) begin
            bad++; $display("FAIL dwa_first: got therm=%h v=%b ptr=%0d want 003ff 1 10",
                            therm_out, out_valid, ptr_out);
        end
        tick();
        total++;
        if ({therm_out, out_valid} !== {17'h003FF, 1'b0}) begin
            bad++; $display("FAIL dwa_bubble: got therm=%h v=%b want 003ff 0", therm_out, out_valid);
        end
        tick();
        total++;
        if ({therm_out, bin_out, out_valid, ptr_out} !== {17'h1FC07, 6'd0, 1'b1, 5'd3}) begin
            bad++; $display("FAIL dwa_wrap: got therm=%h bin=%h v=%b ptr=%0d want 1fc07 00 1 3",
                            therm_out, bin_out, out_valid, ptr_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dem_en = 1'b1; cal_lsb_sel = 1'b0;
        send(11'd640);
        send(11'd640);
        send(11'd1088);          // n = N_THERM: all units, pointer unchanged
        total++;
        if ({therm_out, out_valid} !== {17'h003FF, 1'b1}) begin
            bad++; $display("FAIL b2b_0: got therm=%h v=%b want 003ff 1", therm_out, out_valid);
        end
        send(11'd5);             // n = 0: no units, pointer unchanged
        total++;
        if ({therm_out, out_valid, ptr_out} !== {17'h1FC07, 1'b1, 5'd3}) begin
            bad++; $display("FAIL b2b_1: got therm=%h v=%b ptr=%0d want 1fc07 1 3",
                            therm_out, out_valid, ptr_out);
        end
        tick();
        total++;
        if ({therm_out, bin_out, out_valid, ptr_out} !== {17'h1FFFF, 6'd0, 1'b1, 5'd3}) begin
            bad++; $display("FAIL b2b_full: got therm=%h bin=%h v=%b ptr=%0d want 1ffff 00 1 3",
                            therm_out, bin_out, out_valid, ptr_out);
        end
        tick();
        total++;
        if ({therm_out, bin_out, out_valid, ptr_out} !== {17'h00000, 6'd5, 1'b1, 5'd3}) begin
            bad++; $display("FAIL b2b_zero: got therm=%h bin=%h v=%b ptr=%0d want 00000 05 1 3",
                            therm_out, bin_out, out_valid, ptr_out);
        end
    endtask

    task automatic test_saturation();
        dem_en = 1'b0; cal_lsb_sel = 1'b0;
        send(11'd2000);
        total++;
        if (sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_set: got %b want 1", sat_flag);
        end
        ticks(2);
        total++;
        if ({therm_out, bin_out, bin0_red_out} !== {17'h1FFFF, 6'h3F, 1'b0}) begin
            bad++; $display("FAIL sat_clamp: got therm=%h bin=%h red=%b want 1ffff 3f 0",
                            therm_out, bin_out, bin0_red_out);
        end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        total++;
        if (sat_flag !== 1'b0) begin
            bad++; $display("FAIL sat_clear: got %b want 0", sat_flag);
        end
        sat_clr = 1'b1; send(11'd1500); sat_clr = 1'b0;
        total++;
        if (sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_set_wins: got %b want 1", sat_flag);
        end
        ticks(2);
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        send(11'd1151);          // exactly CODE_MAX: no saturation
        total++;
        if (sat_flag !== 1'b0) begin
            bad++; $display("FAIL sat_boundary: got %b want 0", sat_flag);
        end
        ticks(2);
        total++;
        if ({therm_out, bin_out, out_valid} !== {17'h1FFFF, 6'h3F, 1'b1}) begin
            bad++; $display("FAIL sat_max_code: got therm=%h bin=%h v=%b want 1ffff 3f 1",
                            therm_out, bin_out, out_valid);
        end
    endtask

    task automatic test_redundant_lsb();
        dem_en = 1'b0; cal_lsb_sel = 1'b1;
        send(11'd65);
        send(11'd127);
        tick();
        total++;
        if ({therm_out, bin_out, bin0_red_out} !== {17'h00001, 6'b000000, 1'b1}) begin
            bad++; $display("FAIL lsb_65: got therm=%h bin=%b red=%b want 00001 000000 1",
                            therm_out, bin_out, bin0_red_out);
        end
        tick();
        total++;
        if ({therm_out, bin_out, bin0_red_out} !== {17'h00001, 6'b111110, 1'b1}) begin
            bad++; $display("FAIL lsb_127: got therm=%h bin=%b red=%b want 00001 111110 1",
                            therm_out, bin_out, bin0_red_out);
        end
        cal_lsb_sel = 1'b0;
    endtask

    task automatic test_dem_toggle();
        do_reset();
        dem_en = 1'b1;
        send(11'd192); ticks(2);
        send(11'd192); ticks(2);
        total++;
        if ({therm_out, ptr_out} !== {17'h00038, 5'd6}) begin
            bad++; $display("FAIL dem_rotate: got therm=%h ptr=%0d want 00038 6", therm_out, ptr_out);
        end
        dem_en = 1'b0;
        send(11'd128); ticks(2);
        total++;
        if ({therm_out, ptr_out} !== {17'h00003, 5'd0}) begin
            bad++; $display("FAIL dem_off: got therm=%h ptr=%0d want 00003 0", therm_out, ptr_out);
        end
    endtask

    task automatic test_powerdown();
        do_reset();
        dem_en = 1'b1; cal_lsb_sel = 1'b0;
        send(11'd640); ticks(2);
        send(11'd2000);
        send(11'd192);
        total++;
        if ({sat_flag, ptr_out} !== {1'b1, 5'd10}) begin
            bad++; $display("FAIL pd_pre: got sat=%b ptr=%0d want 1 10", sat_flag, ptr_out);
        end
        code_in = 11'd192; code_valid = 1'b1;
        pdb = 1'b0;
        tick();
        total++;
        if ({therm_out, bin_out, bin0_red_out, out_valid, sat_flag, ptr_out} !== 31'd0) begin
            bad++;
            $display("FAIL pd_flush: got therm=%h bin=%h red=%b v=%b sat=%b ptr=%0d want all 0",
                     therm_out, bin_out, bin0_red_out, out_valid, sat_flag, ptr_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({therm_out, out_valid, ptr_out} !== 23'd0) begin
                bad++; $display("FAIL pd_hold%0d: got therm=%h v=%b ptr=%0d want 0 0 0",
                                i, therm_out, out_valid, ptr_out);
            end
        end
        pdb = 1'b1;
        send(11'd64);
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL pd_early_valid: got %b want 0", out_valid);
        end
        tick();
        total++;
        if ({therm_out, out_valid, ptr_out} !== {17'h00001, 1'b1, 5'd1}) begin
            bad++; $display("FAIL pd_resume: got therm=%h v=%b ptr=%0d want 00001 1 1",
                            therm_out, out_valid, ptr_out);
        end
    endtask

    task automatic test_async_reset();
        dem_en = 1'b0; cal_lsb_sel = 1'b0;
        send(11'd200);
        code_in = 11'd200; code_valid = 1'b1;
        #2;
        rstb = 1'b0;             // mid-cycle, no clock edge involved
        #1;
        total++;
        if ({therm_out, bin_out, bin0_red_out, out_valid, sat_flag, ptr_out} !== 31'd0) begin
            bad++;
            $display("FAIL async_reset: got therm=%h bin=%h red=%b v=%b ptr=%0d want all 0",
                     therm_out, bin_out, bin0_red_out, out_valid, ptr_out);
        end
        code_valid = 1'b0;
        tick();
        rstb = 1'b1;
        ticks(2);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL async_idle: got %b want 0", out_valid);
        end
        send(11'd200);
        ticks(2);
        total++;
        if ({therm_out, bin_out, out_valid} !== {17'h00007, 6'b001000, 1'b1}) begin
            bad++; $display("FAIL async_resume: got therm=%h bin=%b v=%b want 00007 001000 1",
                            therm_out, bin_out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_fill();
        test_dwa_wrap();
        test_back_to_back();
        test_saturation();
        test_redundant_lsb();
        test_dem_toggle();
        test_powerdown();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
